// File: rtl/dram_cmd_issuer_pkg.sv
// Shared types, default DDR4 timings and address-field positions for the command issuer.
// Timings are expressed in DRAM cycles; one DRAM cycle spans two CPU_clk cycles.
package dram_cmd_issuer_pkg;

  typedef enum logic [1:0] {
    DATA_READ         = 2'd0,
    DATA_WRITE        = 2'd1,
    INSTRUCTION_FETCH = 2'd2
  } parsed_op_t;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } dram_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACT      = 3'd1,
    ST_WAIT_RCD = 3'd2,
    ST_COL      = 3'd3,
    ST_WAIT_PRE = 3'd4,
    ST_PRE      = 3'd5,
    ST_WAIT_RP  = 3'd6
  } issuer_state_t;

  localparam int DEF_T_RCD   = 24;
  localparam int DEF_T_RAS   = 52;
  localparam int DEF_T_RP    = 24;
  localparam int DEF_T_RTP   = 12;
  localparam int DEF_T_CWL   = 20;
  localparam int DEF_T_BURST = 4;
  localparam int DEF_T_WR    = 20;

  localparam int COL_LO_LSB = 3;
  localparam int COL_LO_W   = 3;
  localparam int BG_LSB     = 6;
  localparam int BG_W       = 2;
  localparam int BANK_LSB   = 8;
  localparam int BANK_W     = 2;
  localparam int COL_HI_LSB = 10;
  localparam int COL_HI_W   = 8;
  localparam int ROW_LSB    = 18;
  localparam int ROW_W      = 14;
  localparam int COL_W      = COL_HI_W + COL_LO_W;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dram_addr_map.sv
// Splits a request address into bank group, bank, row and column fields.
// Purely combinational; no latency, no flow control.
module dram_addr_map
  import dram_cmd_issuer_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] address_in,
  output logic [BG_W-1:0]          bank_group,
  output logic [BANK_W-1:0]        bank,
  output logic [ROW_W-1:0]         row,
  output logic [COL_W-1:0]         column
);

  logic unused_byte_bits;

  assign bank_group = address_in[BG_LSB +: BG_W];
  assign bank       = address_in[BANK_LSB +: BANK_W];
  assign row        = address_in[ROW_LSB +: ROW_W];
  assign column     = {address_in[COL_HI_LSB +: COL_HI_W], address_in[COL_LO_LSB +: COL_LO_W]};

  // Byte offset within the 8-byte beat never reaches the DRAM.
  assign unused_byte_bits = ^address_in[2:0];

endmodule

// File: rtl/dram_cmd_issuer.sv
// Turns the request-queue head into a closed-page ACT / RD|WR / PRE sequence, one command per DRAM cycle.
// Latency: ACT one cycle after req_valid is seen in a phase-0 cycle; the head is held by the queue until req_pop.
module dram_cmd_issuer
  import dram_cmd_issuer_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int T_RCD         = DEF_T_RCD,
  parameter int T_RAS         = DEF_T_RAS,
  parameter int T_RP          = DEF_T_RP,
  parameter int T_RTP         = DEF_T_RTP,
  parameter int T_CWL         = DEF_T_CWL,
  parameter int T_BURST       = DEF_T_BURST,
  parameter int T_WR          = DEF_T_WR
) (
  input  logic                     CPU_clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  parsed_op_t               opcode_in,
  input  logic [ADDRESS_WIDTH-1:0] address_in,
  output logic                     req_pop,
  output logic                     cmd_valid,
  output dram_cmd_t                cmd,
  output logic [1:0]               bank_group,
  output logic [1:0]               bank,
  output logic [13:0]              row,
  output logic [10:0]              column,
  output logic                     busy
);

  localparam int WR_TO_PRE = T_CWL + T_BURST + T_WR;
  localparam int MAX_IVL   = max_int(max_int(T_RCD, T_RAS),
                                     max_int(max_int(T_RP, T_RTP), WR_TO_PRE));
  localparam int CNT_W     = $clog2(MAX_IVL) + 1;

  logic [BG_W-1:0]   map_bg;
  logic [BANK_W-1:0] map_bank;
  logic [ROW_W-1:0]  map_row;
  logic [COL_W-1:0]  map_col;

  dram_addr_map #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_addr_map (
    .address_in (address_in),
    .bank_group (map_bg),
    .bank       (map_bank),
    .row        (map_row),
    .column     (map_col)
  );

  issuer_state_t     state_q, state_d;
  logic              phase_q, phase_d;
  logic [CNT_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  ras_q, ras_d;
  logic              is_wr_q, is_wr_d;
  logic [BG_W-1:0]   lat_bg_q, lat_bg_d;
  logic [BANK_W-1:0] lat_bank_q, lat_bank_d;
  logic [ROW_W-1:0]  lat_row_q, lat_row_d;
  logic [COL_W-1:0]  lat_col_q, lat_col_d;

  logic              req_pop_q, req_pop_d;
  logic              cmd_valid_q, cmd_valid_d;
  dram_cmd_t         cmd_q, cmd_d;
  logic [BG_W-1:0]   bg_q, bg_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              busy_q, busy_d;

  logic              slot;

  always_comb begin
    // Decisions are made in phase 0 so the registered command lands in phase 1.
    slot        = ~phase_q;
    phase_d     = ~phase_q;
    state_d     = state_q;
    tmr_d       = (phase_q && tmr_q != '0) ? tmr_q - CNT_W'(1) : tmr_q;
    ras_d       = (phase_q && ras_q != '0) ? ras_q - CNT_W'(1) : ras_q;
    is_wr_d     = is_wr_q;
    lat_bg_d    = lat_bg_q;
    lat_bank_d  = lat_bank_q;
    lat_row_d   = lat_row_q;
    lat_col_d   = lat_col_q;
    req_pop_d   = 1'b0;
    cmd_d       = CMD_NOP;
    bg_d        = '0;
    bank_d      = '0;
    row_d       = '0;
    col_d       = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && slot) begin
          state_d    = ST_ACT;
          is_wr_d    = (opcode_in == DATA_WRITE);
          lat_bg_d   = map_bg;
          lat_bank_d = map_bank;
          lat_row_d  = map_row;
          lat_col_d  = map_col;
          tmr_d      = CNT_W'(T_RCD);
          ras_d      = CNT_W'(T_RAS);
          cmd_d      = CMD_ACT;
          bg_d       = map_bg;
          bank_d     = map_bank;
          row_d      = map_row;
        end
      end
      ST_ACT: state_d = ST_WAIT_RCD;
      ST_WAIT_RCD: begin
        if (slot && tmr_q == '0) begin
          state_d   = ST_COL;
          cmd_d     = is_wr_q ? CMD_WR : CMD_RD;
          req_pop_d = 1'b1;
          tmr_d     = is_wr_q ? CNT_W'(WR_TO_PRE) : CNT_W'(T_RTP);
          bg_d      = lat_bg_q;
          bank_d    = lat_bank_q;
          row_d     = lat_row_q;
          col_d     = lat_col_q;
        end
      end
      ST_COL: state_d = ST_WAIT_PRE;
      ST_WAIT_PRE: begin
        if (slot && tmr_q == '0 && ras_q == '0) begin
          state_d = ST_PRE;
          cmd_d   = CMD_PRE;
          tmr_d   = CNT_W'(T_RP);
          bg_d    = lat_bg_q;
          bank_d  = lat_bank_q;
          row_d   = lat_row_q;
        end
      end
      ST_PRE: state_d = ST_WAIT_RP;
      ST_WAIT_RP: begin
        if (slot && tmr_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_valid_d = (cmd_d != CMD_NOP);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge CPU_clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      tmr_q       <= '0;
      ras_q       <= '0;
      is_wr_q     <= 1'b0;
      lat_bg_q    <= '0;
      lat_bank_q  <= '0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
      req_pop_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      bg_q        <= '0;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tmr_q       <= tmr_d;
      ras_q       <= ras_d;
      is_wr_q     <= is_wr_d;
      lat_bg_q    <= lat_bg_d;
      lat_bank_q  <= lat_bank_d;
      lat_row_q   <= lat_row_d;
      lat_col_q   <= lat_col_d;
      req_pop_q   <= req_pop_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      bg_q        <= bg_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      col_q       <= col_d;
      busy_q      <= busy_d;
    end
  end

  assign req_pop    = req_pop_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd        = cmd_q;
  assign bank_group = bg_q;
  assign bank       = bank_q;
  assign row        = row_q;
  assign column     = col_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Scoreboard bench for dram_cmd_issuer: stimulus pushes expected commands with their CPU-cycle times,
// a negedge monitor pops and compares every command the DUT emits.
module tb_dram_cmd_issuer;
  import dram_cmd_issuer_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid;
  parsed_op_t  opcode_in;
  logic [31:0] address_in;
  logic        req_pop;
  logic        cmd_valid;
  dram_cmd_t   cmd;
  logic [1:0]  bank_group;
  logic [1:0]  bank;
  logic [13:0] row;
  logic [10:0] column;
  logic        busy;

  dram_cmd_issuer dut (
    .CPU_clk    (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .opcode_in  (opcode_in),
    .address_in (address_in),
    .req_pop    (req_pop),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .bank_group (bank_group),
    .bank       (bank),
    .row        (row),
    .column     (column),
    .busy       (busy)
  );

  typedef struct {
    dram_cmd_t   c;
    int          t;
    logic [1:0]  g;
    logic [1:0]  b;
    logic [13:0] r;
    logic [10:0] col;
    logic        pop;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   cyc = 0;
  logic ph = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pops = 0;
  int   exp_pops = 0;
  int   act, a1, a2;

  // Cycle index and DRAM phase as the spec defines them: phase is 0 in the first cycle after reset release.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ph  <= rst_n ? ~ph : 1'b0;
  end

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check_busy(input int c, input logic v);
    wait_until(c);
    @(negedge clk);
    chk("busy", busy, v);
  endtask

  task automatic drive_req(input parsed_op_t op, input logic [31:0] addr);
    req_valid  = 1'b1;
    opcode_in  = op;
    address_in = addr;
  endtask

  task automatic push(input dram_cmd_t c, input int t, input logic [1:0] g, input logic [1:0] b,
                      input logic [13:0] r, input logic [10:0] col, input logic p);
    exp_t x;
    x.c = c; x.t = t; x.g = g; x.b = b; x.r = r; x.col = col; x.pop = p;
    sbq.push_back(x);
    if (p) exp_pops++;
  endtask

  // Offsets in CPU cycles from ACT with default timings: column +48, PRE +104 (read) / +136 (write).
  task automatic push_seq(input parsed_op_t op, input int a, input logic [1:0] g, input logic [1:0] b,
                          input logic [13:0] r, input logic [10:0] col);
    logic wr;
    wr = (op == DATA_WRITE);
    push(CMD_ACT, a, g, b, r, 11'd0, 1'b0);
    push(wr ? CMD_WR : CMD_RD, a + 48, g, b, r, col, 1'b1);
    push(CMD_PRE, a + (wr ? 136 : 104), g, b, r, 11'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (req_pop) pops++;
    if (cmd_valid) begin
      chk("cmd_on_phase1", ph, 1);
      if (sbq.size() == 0) begin
        chk("unexpected_cmd", cmd, CMD_NOP);
      end else begin
        e = sbq.pop_front();
        chk("cmd_time", cyc, e.t);
        chk("cmd_fields", {cmd, bank_group, bank, row, column, req_pop},
                          {e.c, e.g, e.b, e.r, e.col, e.pop});
      end
    end else begin
      chk("idle_outputs", {cmd, req_pop, column}, {CMD_NOP, 1'b0, 11'd0});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    opcode_in  = DATA_READ;
    address_in = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd", cmd, CMD_NOP);
    chk("rst_busy", busy, 0);
    chk("rst_req_pop", req_pop, 0);
    chk("rst_fields", {bank_group, bank, row, column}, 0);
    tick();
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      @(negedge clk);
      chk("idle_busy", busy, 0);
    end

    // Read, raised on phase 0: minimum latency.
    while (ph != 1'b0) tick();
    act = cyc + 1;
    drive_req(DATA_READ, 32'h0004_1A48);
    push_seq(DATA_READ, act, 2'd1, 2'd2, 14'd1, 11'h031);
    check_busy(act, 1'b1);
    wait_until(act + 48); tick(); req_valid = 1'b0;
    check_busy(act + 151, 1'b1);
    check_busy(act + 152, 1'b0);

    // Write: write recovery sets PRE, IDLE no earlier than +184.
    while (ph != 1'b0) tick();
    act = cyc + 1;
    drive_req(DATA_WRITE, 32'h0004_1A48);
    push_seq(DATA_WRITE, act, 2'd1, 2'd2, 14'd1, 11'h031);
    wait_until(act + 48); tick(); req_valid = 1'b0;
    check_busy(act + 183, 1'b1);
    check_busy(act + 184, 1'b0);

    // Back-to-back same row: closed page repeats ACT; second ACT at first IDLE phase-0 slot + 1.
    while (ph != 1'b0) tick();
    a1 = cyc + 1;
    drive_req(INSTRUCTION_FETCH, 32'h0004_1A48);
    push_seq(INSTRUCTION_FETCH, a1, 2'd1, 2'd2, 14'd1, 11'h031);
    wait_until(a1 + 48); tick();
    drive_req(DATA_READ, 32'h0004_1A50);
    a2 = a1 + 154;
    push_seq(DATA_READ, a2, 2'd1, 2'd2, 14'd1, 11'h032);
    wait_until(a2 + 48); tick(); req_valid = 1'b0;
    check_busy(a2 + 152, 1'b0);

    // Reset 10 cycles after ACT: no column, no PRE, no pop; head re-served after release.
    while (ph != 1'b0) tick();
    act = cyc + 1;
    drive_req(DATA_WRITE, 32'h0004_1A48);
    push(CMD_ACT, act, 2'd1, 2'd2, 14'd1, 11'd0, 1'b0);
    wait_until(act + 10);
    rst_n = 1'b0;
    wait_until(act + 11);
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_valid", cmd_valid, 0);
    tick();
    rst_n = 1'b1;
    act = cyc + 1;
    push_seq(DATA_WRITE, act, 2'd1, 2'd2, 14'd1, 11'h031);
    wait_until(act + 48); tick(); req_valid = 1'b0;
    check_busy(act + 184, 1'b0);

    // Raised on phase 1: ACT slips one cycle; all-ones address exercises every field boundary.
    while (ph != 1'b1) tick();
    act = cyc + 2;
    drive_req(DATA_READ, 32'hFFFF_FFFF);
    push_seq(DATA_READ, act, 2'd3, 2'd3, 14'h3FFF, 11'h7FF);
    wait_until(act + 48); tick(); req_valid = 1'b0;
    check_busy(act + 152, 1'b0);

    repeat (10) tick();
    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("pop_count", pops, exp_pops);
    chk("pop_total", pops, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
